cmd_stream_encoder: RTL
=======================

// Module: cmd_stream_encoder
// PURPOSE
//  Host-side producer of the RasterIX command stream: turns one request
//  (opcode + immediate + payload length) plus a payload AXIS into header-framed
//  command packets on a single AXIS master. It is the transmitting end of the
//  command parser protocol, used by the on-chip display-list DMA and by the testbench.
//  Opcode and field encodings come from RegisterAndDescriptorDefines.vh.
// PARAMETERS
//  CMD_STREAM_WIDTH  32  Width of the command and payload words, in bits; must be 32, 64 or 128.
//  LEN_WIDTH         19  Width of req_len (payload words per packet).
// PORTS
//  aclk                  in   1                  Clock; all logic on posedge.
//  resetn                in   1                  Synchronous reset, active low.
//  req_valid             in   1                  Request present.
//  req_ready             out  1                  Request accepted when req_valid && req_ready.
//  req_op                in   OP_SIZE            OP_* opcode.
//  req_imm               in   CMD_STREAM_WIDTH   Header immediate bits; bits in OP field ignored.
//  req_len               in   LEN_WIDTH          Payload words for TRIANGLE/TEXTURE.
//  s_payload_axis_tvalid in   1                  Payload word valid.
//  s_payload_axis_tready out  1                  Payload word taken.
//  s_payload_axis_tdata  in   CMD_STREAM_WIDTH   Payload word.
//  m_cmd_axis_tvalid     out  1                  Command word valid (registered).
//  m_cmd_axis_tready     in   1                  Downstream ready.
//  m_cmd_axis_tlast      out  1                  Last word of a packet (registered).
//  m_cmd_axis_tdata      out  CMD_STREAM_WIDTH   Command word (registered).
//  busy                  out  1                  High when not IDLE or output register full.
// BEHAVIOUR
//  Reset values: m_cmd_axis_tvalid=0, m_cmd_axis_tlast=0, m_cmd_axis_tdata=0,
//  req_ready=1, s_payload_axis_tready=0, busy=0.
//  Output stage: one register. It loads a word when (!m_tvalid || m_tready).
//  tdata and tlast are held stable while tvalid && !tready.
//  States:
//   IDLE: req_ready=1. On accept, capture op, imm and the word count N, then go to HEADER.
//   HEADER: when the output register is free, load the header. Header = req_imm with
//    req_op written into [OP_POS +: OP_SIZE]. Then:
//    - N==0: set tlast=1 and go to IDLE.
//    - otherwise: tlast=0, go to PAYLOAD.
//   PAYLOAD: s_payload_axis_tready = !m_tvalid || m_tready. Each payload beat is
//    forwarded unchanged and decrements the counter. The beat taken while cnt==1
//    carries tlast=1 and returns to IDLE.
//  Word count N and header fields per opcode:
//   - TRIANGLE_STREAM: N=req_len. Size field [0 +: OP_TRIANGLE_STEEAM_SIZE_SIZE]
//     = req_len << log2(CMD_STREAM_WIDTH/8), i.e. a byte count.
//   - TEXTURE_STREAM: N=req_len. TEXTURE_STREAM_SIZE field = req_len; TMU_NR field comes from imm.
//   - FOG_LUT_STREAM: N=66 fixed; req_len ignored.
//   - RENDER_CONFIG: N=1; imm[4:0] is the register index.
//   - FRAMEBUFFER, NOP and unknown opcodes: N=0 (header only, tlast on header).
//  Throughput: 1 word/cycle with continuous tready and payload.
//  Back-to-back requests: IDLE->HEADER costs one cycle, so there is at most one bubble between packets.
//  Payload tvalid low mid-packet: output tvalid drops, the counter holds, no tlast is emitted.
//  Reset mid-packet: the packet is abandoned and m_tvalid=0 on the next cycle.
//   Encoder and parser must be reset together.
//  busy deasserts only when IDLE and the output register is empty (or draining its last word).
// TESTING
//  1. NOP request, tready=1 -> exactly 1 word, OP field=NOP, tlast=1, req_ready back high 2 cycles later.
//  2. TRIANGLE len=12, W=32 -> header size field=48, then 12 payload words in order,
//     tlast only on word 12.
//  3. TEXTURE len=4, tmu=1, tready toggling 1010... -> 5 words, data and tlast stable while stalled,
//     no loss or duplication.
//  4. FOG request with req_len=3 -> 67 words total, 66 payload words consumed.
//  5. RENDER_CONFIG idx=5 then FRAMEBUFFER back-to-back -> 2-word packet then 1-word packet,
//     2 tlast pulses, <=1 idle cycle between them.
//  6. Reset asserted after 3 of 8 TRIANGLE payload words -> tvalid=0 next cycle,
//     req_ready=1, a new NOP encodes cleanly.

Source files
------------

// File: rtl/cmd_stream_encoder.sv
// cmd_stream_encoder: turns one request (opcode, immediate, payload length)
// plus a payload AXI stream into a header-framed RasterIX command packet on a
// single registered AXI stream master.
module cmd_stream_encoder #(
  parameter int CMD_STREAM_WIDTH = 32,
  parameter int LEN_WIDTH        = 19,
  parameter int OP_POS           = 28,
  parameter int OP_SIZE          = 4
) (
  input  logic                        aclk,
  input  logic                        resetn,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [OP_SIZE-1:0]          req_op,
  input  logic [CMD_STREAM_WIDTH-1:0] req_imm,
  input  logic [LEN_WIDTH-1:0]        req_len,
  input  logic                        s_payload_axis_tvalid,
  output logic                        s_payload_axis_tready,
  input  logic [CMD_STREAM_WIDTH-1:0] s_payload_axis_tdata,
  output logic                        m_cmd_axis_tvalid,
  input  logic                        m_cmd_axis_tready,
  output logic                        m_cmd_axis_tlast,
  output logic [CMD_STREAM_WIDTH-1:0] m_cmd_axis_tdata,
  output logic                        busy
);

  // Opcodes shared with the command parser.
  localparam logic [OP_SIZE-1:0] OP_NOP_STREAM      = OP_SIZE'(0);
  localparam logic [OP_SIZE-1:0] OP_TEXTURE_STREAM  = OP_SIZE'(1);
  localparam logic [OP_SIZE-1:0] OP_RENDER_CONFIG   = OP_SIZE'(2);
  localparam logic [OP_SIZE-1:0] OP_FRAMEBUFFER     = OP_SIZE'(3);
  localparam logic [OP_SIZE-1:0] OP_TRIANGLE_STREAM = OP_SIZE'(4);
  localparam logic [OP_SIZE-1:0] OP_FOG_LUT_STREAM  = OP_SIZE'(5);

  // Header size fields; both start at bit 0.
  localparam int OP_TRIANGLE_STREAM_SIZE_SIZE = 16;
  localparam int TEXTURE_STREAM_SIZE_SIZE     = 18;
  localparam int FOG_LUT_WORDS                = 66;

  // Triangle size is a byte count: words scaled by the bytes per word.
  localparam int BYTE_SHIFT = $clog2(CMD_STREAM_WIDTH / 8);
  // Counter must hold req_len, the fog table length and the texture size field.
  localparam int CNT_W = (LEN_WIDTH > TEXTURE_STREAM_SIZE_SIZE) ? LEN_WIDTH
                                                                : TEXTURE_STREAM_SIZE_SIZE;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [OP_SIZE-1:0]          op_q, op_d;
  logic [CMD_STREAM_WIDTH-1:0] imm_q, imm_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        tvalid_q, tvalid_d;
  logic                        tlast_q, tlast_d;
  logic [CMD_STREAM_WIDTH-1:0] tdata_q, tdata_d;

  logic                        out_free;
  logic [CNT_W-1:0]            req_words;
  logic [CMD_STREAM_WIDTH-1:0] header;

  // The output register can take a new word when empty or being drained.
  assign out_free              = !tvalid_q || m_cmd_axis_tready;
  assign req_ready             = (state_q == ST_IDLE);
  assign s_payload_axis_tready = (state_q == ST_PAYLOAD) && out_free;
  assign m_cmd_axis_tvalid     = tvalid_q;
  assign m_cmd_axis_tlast      = tlast_q;
  assign m_cmd_axis_tdata      = tdata_q;
  assign busy                  = (state_q != ST_IDLE) || (tvalid_q && !m_cmd_axis_tready);

  // Payload word count implied by the requested opcode.
  always_comb begin
    case (req_op)
      OP_TRIANGLE_STREAM,
      OP_TEXTURE_STREAM:  req_words = CNT_W'(req_len);
      OP_FOG_LUT_STREAM:  req_words = CNT_W'(FOG_LUT_WORDS);
      OP_RENDER_CONFIG:   req_words = CNT_ONE;
      default:            req_words = '0;
    endcase
  end

  // Header word: immediate with size field and opcode overlaid.
  always_comb begin
    header = imm_q;
    case (op_q)
      OP_TRIANGLE_STREAM:
        header[0 +: OP_TRIANGLE_STREAM_SIZE_SIZE] =
          OP_TRIANGLE_STREAM_SIZE_SIZE'(cnt_q << BYTE_SHIFT);
      OP_TEXTURE_STREAM:
        header[0 +: TEXTURE_STREAM_SIZE_SIZE] = cnt_q[TEXTURE_STREAM_SIZE_SIZE-1:0];
      default: ;
    endcase
    header[OP_POS +: OP_SIZE] = op_q;
  end

  // Packet sequencing and output register next-state.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    imm_d    = imm_q;
    cnt_d    = cnt_q;
    tvalid_d = tvalid_q && !m_cmd_axis_tready;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          imm_d   = req_imm;
          cnt_d   = req_words;
          state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (out_free) begin
          tvalid_d = 1'b1;
          tdata_d  = header;
          tlast_d  = (cnt_q == '0);
          state_d  = (cnt_q == '0) ? ST_IDLE : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (out_free && s_payload_axis_tvalid) begin
          tvalid_d = 1'b1;
          tdata_d  = s_payload_axis_tdata;
          tlast_d  = (cnt_q == CNT_ONE);
          cnt_d    = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOP_STREAM;
      imm_q    <= '0;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      imm_q    <= imm_d;
      cnt_q    <= cnt_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
    end
  end

endmodule
